adma_wbm_arb: RTL

Round-robin arbiter that shares the single 64-bit Wishbone master port of the ADMA engine among its internal requesters: descriptor fetch, source read and destination write. It sits between the engine's sub-blocks and the external `wbm_*` bus. It grants whole `cyc` tenures, so bursts and descriptor reads are never split. A watchdog aborts tenures whose slave never terminates a cycle.

---
 rtl/adma_pkg.sv | 19 +
 rtl/adma_rr_pick.sv | 29 ++
 rtl/adma_wbm_arb.sv | 120 ++++++++++++
 3 files changed

// File: rtl/adma_pkg.sv
// Shared constants for the ADMA Wishbone master arbiter: FSM encodings,
// requester indices and parameter defaults.
package adma_pkg;
  localparam int NREQ_DEF = 3;
  localparam int TMO_DEF  = 255;

  localparam logic [1:0] ARB_IDLE    = 2'd0;
  localparam logic [1:0] ARB_OWN     = 2'd1;
  localparam logic [1:0] ARB_ABORT   = 2'd2;
  localparam logic [1:0] ARB_RELEASE = 2'd3;

  localparam int REQ_DESC = 0;
  localparam int REQ_SRC  = 1;
  localparam int REQ_DST  = 2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/adma_rr_pick.sv
// Rotating priority encoder: first set request searching from last+1,
// wrapping modulo NREQ; returns a one-hot winner and its index.
module adma_rr_pick
  import adma_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  localparam int IW = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   idx,
  output logic            any
);

  always_comb begin
    win = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!any && req[(int'(last) + i) % NREQ]) begin
        any = 1'b1;
        win[(int'(last) + i) % NREQ] = 1'b1;
        idx = IW'((int'(last) + i) % NREQ);
      end
    end
  end

endmodule

// File: rtl/adma_wbm_arb.sv
// Round-robin arbiter sharing the ADMA 64-bit Wishbone master port between
// descriptor fetch, source read and destination write, with a bus watchdog.
module adma_wbm_arb
  import adma_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int TMO  = TMO_DEF
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [NREQ-1:0]    req_cyc_i,
  input  logic [NREQ-1:0]    req_stb_i,
  input  logic [NREQ-1:0]    req_we_i,
  input  logic [NREQ-1:0]    req_cab_i,
  input  logic [NREQ*32-1:0] req_adr_i,
  input  logic [NREQ*4-1:0]  req_sel_i,
  input  logic [NREQ*32-1:0] req_dat_i,
  input  logic [NREQ*32-1:0] req_dat64_i,
  output logic [NREQ-1:0]    req_ack_o,
  output logic [NREQ-1:0]    req_err_o,
  output logic [NREQ-1:0]    req_rty_o,
  output logic [31:0]        req_dat_o,
  output logic [31:0]        req_dat64_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic               wbm_we_o,
  output logic               wbm_cab_o,
  output logic [31:0]        wbm_adr_o,
  output logic [3:0]         wbm_sel_o,
  output logic [31:0]        wbm_dat_o,
  output logic [31:0]        wbm_dat64_o,
  input  logic               wbm_ack_i,
  input  logic               wbm_err_i,
  input  logic               wbm_rty_i,
  input  logic [31:0]        wbm_dat_i,
  input  logic [31:0]        wbm_dat64_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic [1:0]         arb_state_o
);

  localparam int         IW     = idx_w(NREQ);
  localparam logic [7:0] TMO_M1 = 8'(TMO - 1);

  logic [1:0]      state;
  logic [IW-1:0]   own_idx;
  logic [IW-1:0]   last_idx;
  logic [7:0]      wd_cnt;
  logic [NREQ-1:0] pick_win;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            act, term, stall, tmo;

  adma_rr_pick #(.NREQ(NREQ)) u_pick (
    .req  (req_cyc_i),
    .last (last_idx),
    .win  (pick_win),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // gnt_o is only non-zero in OWN, so it alone gates the bus mux
  assign act         = |gnt_o;
  assign wbm_cyc_o   = act & req_cyc_i[own_idx];
  assign wbm_stb_o   = wbm_cyc_o & req_stb_i[own_idx];
  assign wbm_we_o    = act & req_we_i[own_idx];
  assign wbm_cab_o   = act & req_cab_i[own_idx];
  assign wbm_adr_o   = act ? req_adr_i[32*own_idx +: 32]   : '0;
  assign wbm_sel_o   = act ? req_sel_i[4*own_idx +: 4]     : '0;
  assign wbm_dat_o   = act ? req_dat_i[32*own_idx +: 32]   : '0;
  assign wbm_dat64_o = act ? req_dat64_i[32*own_idx +: 32] : '0;

  assign req_dat_o   = wbm_dat_i;
  assign req_dat64_o = wbm_dat64_i;
  assign arb_state_o = state;

  // A termination in the timeout cycle masks the stall, so it wins
  assign term  = wbm_ack_i | wbm_err_i | wbm_rty_i;
  assign stall = wbm_stb_o & ~term;
  assign tmo   = stall & (wd_cnt == TMO_M1);

  assign req_ack_o = gnt_o & {NREQ{wbm_cyc_o & wbm_ack_i}};
  assign req_err_o = gnt_o & {NREQ{(wbm_cyc_o & wbm_err_i) | tmo}};
  assign req_rty_o = gnt_o & {NREQ{wbm_cyc_o & wbm_rty_i}};

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state    <= ARB_IDLE;
      gnt_o    <= '0;
      own_idx  <= '0;
      last_idx <= IW'(NREQ - 1);
      wd_cnt   <= '0;
    end else begin
      wd_cnt <= (state == ARB_OWN && stall && !tmo) ? wd_cnt + 8'd1 : 8'd0;
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            state    <= ARB_OWN;
            gnt_o    <= pick_win;
            own_idx  <= pick_idx;
            last_idx <= pick_idx;
          end
        end
        ARB_OWN: begin
          if (!req_cyc_i[own_idx]) begin
            state <= ARB_RELEASE;
            gnt_o <= '0;
          end else if (tmo) begin
            state <= ARB_ABORT;
            gnt_o <= '0;
          end
        end
        ARB_ABORT: begin
          if (!req_cyc_i[own_idx]) state <= ARB_RELEASE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
